// File: rtl/global_types.sv
// Shared types for the frame-release path: the Avalon-ST word layout,
// the release-gate FSM encoding and the default counter width.
package global_types;

    // Default width of the frame/verdict/start counters; the decision
    // stage uses the same width so the modular arithmetic lines up.
    localparam int CTR_SIZE_DEF = 24;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
        logic        sop;
        logic        eop;
    } avln_st;

    typedef enum logic [1:0] {
        G_IDLE   = 2'd0,
        G_WAIT   = 2'd1,
        G_STREAM = 2'd2
    } gate_state_t;

endpackage

// File: rtl/verdict_credit.sv
// Frame bookkeeping for verdict_gate: counts arrived frames, verdicts and
// started frames, and derives release credit plus the upstream backlog.
module verdict_credit
    import global_types::*;
#(
    parameter int  CTR_SIZE    = CTR_SIZE_DEF,
    parameter int  MAX_PENDING = 16,
    localparam int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              arrive,
    input  logic              verdict,
    input  logic              start,
    output logic              credit_pos,
    output logic [PEND_W-1:0] pending,
    output logic              stall
);

    logic [CTR_SIZE-1:0] arrived_cnt;
    logic [CTR_SIZE-1:0] verdict_cnt;
    logic [CTR_SIZE-1:0] start_cnt;
    logic [CTR_SIZE-1:0] credit;
    logic [CTR_SIZE-1:0] backlog;

    // Free-running wrapping event counters; only their differences matter.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            arrived_cnt <= '0;
            verdict_cnt <= '0;
            start_cnt   <= '0;
        end else begin
            if (arrive)  arrived_cnt <= arrived_cnt + 1'b1;
            if (verdict) verdict_cnt <= verdict_cnt + 1'b1;
            if (start)   start_cnt   <= start_cnt + 1'b1;
        end
    end

    // Credit goes negative after a timeout release until the late verdict lands.
    assign credit     = verdict_cnt - start_cnt;
    assign credit_pos = ~credit[CTR_SIZE-1] & (|credit);
    assign backlog    = arrived_cnt - start_cnt;

    // Saturate the backlog; a cut-through start ahead of its own eop reads as zero.
    always_comb begin
        pending = '0;
        if (backlog[CTR_SIZE-1]) begin
            pending = '0;
        end else if (backlog >= CTR_SIZE'(MAX_PENDING)) begin
            pending = PEND_W'(MAX_PENDING);
        end else begin
            pending = backlog[PEND_W-1:0];
        end
    end

    assign stall = (pending >= PEND_W'(MAX_PENDING));

endmodule

// File: rtl/verdict_gate.sv
// Release scheduler for the frame FIFO ahead of the drop-decision stage.
// A frame is held at the FIFO head until its verdict exists, then drained
// word by word under downstream backpressure.
// Build option: define VERDICT_TIMEOUT_EN to release a head frame that
// has waited TIMEOUT cycles without a verdict (counted in timeout_cnt).
//
// state    | meaning
// G_IDLE   | inspect head: drop stray non-sop words, or decide on a new frame
// G_WAIT   | sop at head, no credit yet; optional timeout timer running
// G_STREAM | draining the current frame until its eop is popped
module verdict_gate
    import global_types::*;
#(
    parameter int  CTR_SIZE    = CTR_SIZE_DEF,
    parameter int  MAX_PENDING = 16,
    parameter int  TIMEOUT     = 4096,
    localparam int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  avln_st              in,
    input  logic                verdict,
    input  logic                fifo_empty,
    input  avln_st              fifo_out,
    input  logic                out_ready,
    output logic                fifo_rdreq,
    output logic                stall,
    output logic [PEND_W-1:0]   pending,
    output logic [CTR_SIZE-1:0] timeout_cnt,
    output logic [CTR_SIZE-1:0] resync_cnt
);

    gate_state_t state;
    gate_state_t state_nxt;
    logic        credit_pos;
    logic        start_pop;
    logic        resync_pop;
    logic        timeout_hit;
    logic        head_sop;

    assign head_sop = ~fifo_empty & fifo_out.sop;

    verdict_credit #(
        .CTR_SIZE    (CTR_SIZE),
        .MAX_PENDING (MAX_PENDING)
    ) u_credit (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .arrive     (in.valid & in.eop),
        .verdict    (verdict),
        .start      (start_pop),
        .credit_pos (credit_pos),
        .pending    (pending),
        .stall      (stall)
    );

`ifdef VERDICT_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMR_W-1:0] timer;

    assign timeout_hit = (state == G_WAIT) && (timer == TMR_W'(TIMEOUT - 1));

    // Wait timer: cleared while idle so every G_WAIT entry starts from zero.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (state == G_IDLE) begin
            timer <= '0;
        end else if (state == G_WAIT && !credit_pos) begin
            timer <= timer + 1'b1;
        end
    end

    // Count frames released without a verdict; a real verdict takes priority.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_cnt <= '0;
        end else if (timeout_hit && !credit_pos) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign timeout_cnt    = '0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // State register.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= G_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt = state;
        case (state)
            G_IDLE: begin
                if (head_sop) begin
                    state_nxt = credit_pos ? G_STREAM : G_WAIT;
                end
            end
            G_WAIT: begin
                if (credit_pos || timeout_hit) begin
                    state_nxt = G_STREAM;
                end
            end
            G_STREAM: begin
                if (fifo_rdreq && fifo_out.eop) begin
                    state_nxt = G_IDLE;
                end
            end
            default: state_nxt = G_IDLE;
        endcase
    end

    // Pop control: stray words are discarded regardless of out_ready.
    always_comb begin
        fifo_rdreq = 1'b0;
        start_pop  = 1'b0;
        resync_pop = 1'b0;
        case (state)
            G_IDLE: begin
                resync_pop = ~fifo_empty & ~fifo_out.sop;
                fifo_rdreq = resync_pop;
            end
            G_STREAM: begin
                fifo_rdreq = out_ready & ~fifo_empty;
                start_pop  = fifo_rdreq & fifo_out.sop;
            end
            default: begin
                fifo_rdreq = 1'b0;
            end
        endcase
    end

    // Discarded non-sop head words.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            resync_cnt <= '0;
        end else if (resync_pop) begin
            resync_cnt <= resync_cnt + 1'b1;
        end
    end

    logic unused_fields;
    assign unused_fields = &{1'b0, in.data, in.sop, fifo_out.data, fifo_out.valid};

endmodule

// File: tb/tb_verdict_gate.sv
// Directed bench for verdict_gate. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_verdict_gate;
    import global_types::*;

    localparam int CTR  = 24;
    localparam int MAXP = 16;
    localparam int TO   = 16;
    localparam int PW   = $clog2(MAXP + 1);
`ifdef VERDICT_TIMEOUT_EN
    localparam int EXP_TMO = 1;
`else
    localparam int EXP_TMO = 0;
`endif

    logic           sys_clk = 1'b0;
    logic           reset_n;
    avln_st         in_s;
    avln_st         head_s;
    logic           verdict;
    logic           fifo_empty;
    logic           out_ready;
    logic           fifo_rdreq;
    logic           stall;
    logic [PW-1:0]  pending;
    logic [CTR-1:0] timeout_cnt;
    logic [CTR-1:0] resync_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 sys_clk = ~sys_clk;

    verdict_gate #(
        .CTR_SIZE    (CTR),
        .MAX_PENDING (MAXP),
        .TIMEOUT     (TO)
    ) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .in          (in_s),
        .verdict     (verdict),
        .fifo_empty  (fifo_empty),
        .fifo_out    (head_s),
        .out_ready   (out_ready),
        .fifo_rdreq  (fifo_rdreq),
        .stall       (stall),
        .pending     (pending),
        .timeout_cnt (timeout_cnt),
        .resync_cnt  (resync_cnt)
    );

    typedef struct {
        logic rst;
        logic arr;
        logic vd;
        logic emp;
        logic hsop;
        logic heop;
        logic rdy;
        logic rd;
        int   pend;
        logic stl;
        int   rsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, arr, vd, emp, hsop, heop, rdy,
                                input logic rd, input int pend, input logic stl,
                                input int rsy);
        vec_t v;
        v.rst = rst; v.arr = arr; v.vd = vd; v.emp = emp;
        v.hsop = hsop; v.heop = heop; v.rdy = rdy;
        v.rd = rd; v.pend = pend; v.stl = stl; v.rsy = rsy;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic arr, vd, emp, hsop, heop, rdy);
        @(negedge sys_clk);
        in_s        = '0;
        in_s.valid  = arr;
        in_s.eop    = arr;
        verdict     = vd;
        fifo_empty  = emp;
        head_s      = '0;
        head_s.valid = ~emp;
        head_s.sop  = hsop;
        head_s.eop  = heop;
        head_s.data = 32'h0000_00A5;
        out_ready   = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        reset_n    = 1'b0;
        in_s       = '0;
        head_s     = '0;
        verdict    = 1'b0;
        fifo_empty = 1'b1;
        out_ready  = 1'b1;
        @(negedge sys_clk);
        reset_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int  n;
        int  w;
        bit  seen;
        logic rdy;

        reset_n    = 1'b0;
        in_s       = '0;
        head_s     = '0;
        verdict    = 1'b0;
        fifo_empty = 1'b1;
        out_ready  = 1'b1;

        //                 rst arr vd emp sop eop rdy | rd pend stl rsy
        // Resync, then one 4-word frame held until its verdict.
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1,  0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1,  0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 2));
        // Three frames with verdicts banked ahead, back-to-back drain.
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1,  0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1,  0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1,  0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  1, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,  1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1,  1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,  1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1,  1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1,  1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].arr, tbl[i].vd, tbl[i].emp, tbl[i].hsop, tbl[i].heop, tbl[i].rdy);
            chk($sformatf("vec%0d_rdreq", i),   fifo_rdreq, tbl[i].rd);
            chk($sformatf("vec%0d_pending", i), pending,    tbl[i].pend);
            chk($sformatf("vec%0d_stall", i),   stall,      tbl[i].stl);
            chk($sformatf("vec%0d_resync", i),  resync_cnt, tbl[i].rsy);
            chk($sformatf("vec%0d_timeout", i), timeout_cnt, 0);
        end

        // Frame with no verdict: timeout release (or indefinite wait).
        do_reset();
        drive(1, 0, 0, 1, 0, 1);
        chk("to_enter_wait_rdreq", fifo_rdreq, 0);
        n = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 0, 1, 0, 1);
            if (fifo_rdreq) begin
                seen = 1;
                break;
            end
            n++;
        end
`ifdef VERDICT_TIMEOUT_EN
        chk("to_release_cycles", n, TO);
        drive(0, 0, 0, 0, 1, 1);
        chk("to_eop_rdreq", fifo_rdreq, 1);
        drive(0, 1, 1, 0, 0, 1);
        chk("to_count", timeout_cnt, 1);
        chk("to_pending", pending, 0);
`else
        chk("wait_no_release", seen, 0);
        chk("wait_timeout_cnt", timeout_cnt, 0);
        drive(0, 1, 0, 1, 0, 1);
        chk("wait_vd_rdreq", fifo_rdreq, 0);
        drive(0, 0, 0, 1, 0, 1);
        chk("wait_to_stream_rdreq", fifo_rdreq, 0);
        drive(0, 0, 0, 1, 0, 1);
        chk("wait_sop_rdreq", fifo_rdreq, 1);
        drive(0, 0, 0, 0, 1, 1);
        chk("wait_eop_rdreq", fifo_rdreq, 1);
        drive(0, 0, 1, 0, 0, 1);
        chk("wait_pending", pending, 0);
`endif
        drive(1, 0, 0, 1, 0, 1);
        chk("next_enter_rdreq", fifo_rdreq, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 1);
            chk($sformatf("next_hold%0d_rdreq", i), fifo_rdreq, 0);
        end
        drive(0, 1, 0, 1, 0, 1);
        chk("next_vd_rdreq", fifo_rdreq, 0);
        drive(0, 0, 0, 1, 0, 1);
        chk("next_latency_rdreq", fifo_rdreq, 0);
        drive(0, 0, 0, 1, 1, 1);
        chk("next_release_rdreq", fifo_rdreq, 1);
        drive(0, 0, 1, 0, 0, 1);
        chk("next_pending", pending, 0);
        chk("next_timeout_cnt", timeout_cnt, EXP_TMO);

        // Reset clears the statistics.
        do_reset();
        drive(0, 0, 1, 0, 0, 1);
        chk("rst_timeout_cnt", timeout_cnt, 0);
        chk("rst_resync_cnt", resync_cnt, 0);
        chk("rst_pending", pending, 0);
        chk("rst_stall", stall, 0);

        // Backlog threshold and saturation.
        for (int k = 0; k < MAXP; k++) begin
            drive(1, 0, 1, 0, 0, 1);
            chk($sformatf("fill%0d_pending", k), pending, k);
            chk($sformatf("fill%0d_stall", k), stall, 0);
        end
        drive(0, 1, 1, 0, 0, 1);
        chk("full_pending", pending, MAXP);
        chk("full_stall", stall, 1);
        drive(0, 0, 0, 1, 1, 1);
        chk("full_decide_rdreq", fifo_rdreq, 0);
        drive(0, 0, 0, 1, 1, 1);
        chk("full_release_rdreq", fifo_rdreq, 1);
        drive(0, 0, 1, 0, 0, 1);
        chk("drain_pending", pending, MAXP - 1);
        chk("drain_stall", stall, 0);
        drive(1, 0, 1, 0, 0, 1);
        drive(1, 0, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 1);
        chk("sat_pending", pending, MAXP);
        chk("sat_stall", stall, 1);

        // 6-word frame under alternating out_ready.
        do_reset();
        drive(1, 1, 1, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 1);
        chk("bp_decide_rdreq", fifo_rdreq, 0);
        w = 0;
        for (int i = 0; i < 20 && w < 6; i++) begin
            rdy = ((i % 2) == 0);
            drive(0, 0, 0, (w == 0), (w == 5), rdy);
            chk($sformatf("bp%0d_rdreq", i), fifo_rdreq, rdy);
            if (rdy) w++;
        end
        chk("bp_words", w, 6);
        drive(0, 0, 0, 1, 0, 1);
        chk("bp_idle_after_eop", fifo_rdreq, 0);
        drive(0, 0, 0, 1, 0, 1);
        chk("bp_wait_no_credit", fifo_rdreq, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/verdict_gate.md
# verdict_gate

Release scheduler for the frame FIFO that feeds the drop-decision stage. Frames enter the FIFO as they arrive on the Avalon-ST input, while the detector produces one in-order verdict pulse per frame. This block holds each frame at the FIFO head until that frame's verdict has been produced, then drains the whole frame under downstream backpressure. This guarantees the drop bit is written before the decision stage reads it. It also throttles upstream when too many frames are awaiting verdicts.

## Interface
- CTR_SIZE, 24: width of frame/verdict/start counters (matches decision stage)
- MAX_PENDING, 16: frames allowed in FIFO without a start; stall threshold
- TIMEOUT, 4096: cycles a head frame may wait for its verdict (when timeout compiled in)
- sys_clk  in  1  clock; one clock domain, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in  in  avln_st  FIFO write-side stream; only valid, sop and eop are used
- verdict  in  1  one-cycle pulse; detector finished the oldest unjudged frame
- fifo_empty  in  1  show-ahead FIFO empty flag
- fifo_out  in  avln_st  FIFO head word; meaningful only when fifo_empty=0
- out_ready  in  1  downstream may accept a word this cycle
- fifo_rdreq  out  1  pop FIFO head this cycle
- stall  out  1  upstream must stop starting new frames
- pending  out  $clog2(MAX_PENDING+1)  arrived-but-not-started frames, saturating
- timeout_cnt  out  CTR_SIZE  frames released by timeout, wrapping
- resync_cnt  out  CTR_SIZE  non-sop head words discarded in IDLE, wrapping

## Operation
- arrived_cnt increments on in.valid & in.eop.
- verdict_cnt increments on verdict.
- start_cnt increments when the FSM pops a sop word.
- All counters are CTR_SIZE bits and wrap.
- credit = verdict_cnt − start_cnt, interpreted as a CTR_SIZE-bit signed value. A release is allowed when credit > 0.
- pending = arrived_cnt − start_cnt, saturated at MAX_PENDING. stall = (pending ≥ MAX_PENDING).
- FSM states and transitions:
  - G_IDLE:
    - Head present and head not sop → pop it (fifo_rdreq=1), resync_cnt+1, stay in G_IDLE.
    - Head present and is sop, with credit>0 → G_STREAM.
    - Head present and is sop, with credit≤0 → G_WAIT, timer cleared.
  - G_WAIT:
    - credit>0 → G_STREAM.
    - timer==TIMEOUT−1 → G_STREAM, timeout_cnt+1.
    - Otherwise timer+1.
  - G_STREAM:
    - fifo_rdreq = out_ready & ~fifo_empty.
    - A pop with fifo_out.sop increments start_cnt.
    - A pop with fifo_out.eop → G_IDLE.
- A timed-out frame still consumes a start. Its late verdict restores credit to the correct value; credit may therefore go negative transiently.
- fifo_rdreq is combinational from state and inputs. It is never asserted while fifo_empty=1.

## Timing
- Reset values: fifo_rdreq=0, stall=0, pending=0, timeout_cnt=0, resync_cnt=0, all counters 0, state G_IDLE, timer 0.
- Reset may be asserted mid-frame. The FIFO is reset alongside this block; no partial-frame recovery is required.
- Verdict latency: verdict sampled at edge t → credit visible after t → state G_STREAM after edge t+1 → first fifo_rdreq in cycle t+1..t+2.
- Minimum frame throughput: one word per cycle while out_ready=1. One idle cycle occurs between frames (the G_IDLE decision).
- verdict and a sop pop in the same cycle: both counters update, so credit is unchanged.
- verdict while in G_STREAM is banked for later frames.
- in.eop and a sop pop in the same cycle: pending is unchanged.
- fifo_empty in mid-frame during G_STREAM: hold state, fifo_rdreq=0.
- out_ready=0 during G_STREAM: fifo_rdreq=0, no state change.
- Counter wrap is harmless because credit and pending are computed as modular differences.

## Configuration
- VERDICT_TIMEOUT_EN defined: G_WAIT timer and timeout release are active.
- VERDICT_TIMEOUT_EN undefined: G_WAIT waits indefinitely for credit>0, the timer is not built, and timeout_cnt is tied to 0.

## Structure
- global_types holds:
  - avln_st (existing).
  - typedef enum logic [1:0] gate_state_t {G_IDLE, G_WAIT, G_STREAM}.
  - A shared default for CTR_SIZE.
- One sub-module, verdict_credit, holds the three counters and produces credit_pos, pending and stall.
- The FSM, timer and statistics counters stay in verdict_gate.

## Test plan
- Single 4-word frame, verdict 10 cycles after eop, out_ready=1 → 4 consecutive pops starting 1–2 cycles after verdict; credit returns to 0.
- Three frames queued, three verdict pulses before the first sop reaches the head → frames drain back-to-back with one G_IDLE cycle between them; start_cnt=3.
- No verdict, TIMEOUT=8, macro defined → frame released 8 cycles after entering G_WAIT, timeout_cnt=1. A later verdict restores credit to 0 and the next frame waits normally.
- 16 frames arrive with no verdicts, MAX_PENDING=16 → stall=1 on the 16th eop. One release drops pending to 15 and stall to 0.
- Head word without sop after reset (e.g. a mid-frame word) → single pop, resync_cnt=1, no stream output.
- out_ready toggled 1,0,1,0 during a 6-word frame → pops occur only on ready cycles; eop pop returns the FSM to G_IDLE.
